// File: rtl/srff_pkg.sv
// Shared types and constants for the SR flip-flop command driver.
package srff_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_RST  = 2'b01,
    OP_SET  = 2'b10,
    OP_TGL  = 2'b11
  } srff_op_t;

  typedef logic [1:0] srff_drv_state_t;

  localparam srff_drv_state_t IDLE   = 2'd0;
  localparam srff_drv_state_t DRIVE  = 2'd1;
  localparam srff_drv_state_t WAIT_Q = 2'd2;

  // The one {s, r} combination the downstream flop must never see.
  localparam logic [1:0] SR_FORBIDDEN = 2'b11;

  // Toggle becomes a concrete set or reset from the flop's present state.
  function automatic srff_op_t resolve_op(input srff_op_t op, input logic q);
    if (op == OP_TGL) return q ? OP_RST : OP_SET;
    return op;
  endfunction

endpackage

// File: rtl/srff_drv_cnt.sv
// Loadable down-counter with a terminal flag that is high while the count equals 1.
module srff_drv_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    // NOTE: default assignment first, so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  // NOTE: state registers use non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign term = (cnt_q == W'(1));

endmodule

// File: rtl/srff_driver.sv
// Valid/ready command driver producing clean s/r strobes for an SR flop.
// Define SRFF_DRIVER_VERIFY_EN to add q readback with timeout and sticky err.
module srff_driver
  import srff_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [LEN_W-1:0] req_len,
  input  logic             q_in,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             err
);

  srff_drv_state_t state_q, state_d;
  srff_op_t        op_q, op_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            accept;
  logic            len_term;

  assign accept = (state_q == IDLE) && req_valid;

  srff_drv_cnt #(.W(LEN_W)) u_len_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ((req_len == '0) ? LEN_W'(1) : req_len),
    .dec      (state_q == DRIVE),
    .term     (len_term)
  );

`ifdef SRFF_DRIVER_VERIFY_EN
  logic err_q, err_d;
  logic tmo_term;
  logic q_match;

  // Hold has no target, so it is treated as matching immediately.
  assign q_match = (op_q == OP_HOLD) || (q_in == (op_q == OP_SET));

  srff_drv_cnt #(.W(8)) u_tmo_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     ((state_q == DRIVE) && len_term),
    .load_val (8'(TIMEOUT)),
    .dec      (state_q == WAIT_Q),
    .term     (tmo_term)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    done_d  = 1'b0;
`ifdef SRFF_DRIVER_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = DRIVE;
          op_d    = resolve_op(srff_op_t'(req_op), q_in);
        end
      end
      DRIVE: begin
        if (len_term) begin
`ifdef SRFF_DRIVER_VERIFY_EN
          state_d = WAIT_Q;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef SRFF_DRIVER_VERIFY_EN
      WAIT_Q: begin
        if (q_match) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tmo_term) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    s_d     = (state_d == DRIVE) && (op_d == OP_SET);
    r_d     = (state_d == DRIVE) && (op_d == OP_RST);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

`ifdef SRFF_DRIVER_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

  assign s         = s_q;
  assign r         = r_q;
  assign busy      = busy_q;
  assign req_ready = ready_q;
  assign done      = done_q;

  a_no_forbidden: assert property (@(posedge clk) {s_q, r_q} != SR_FORBIDDEN);
  a_done_alone:   assert property (@(posedge clk) !(done_q && (s_q || r_q)));
  a_timeout_rng:  assert property (@(posedge clk) rst || ((TIMEOUT >= 1) && (TIMEOUT <= 255)));

endmodule

// File: tb/tb_srff_driver.sv
// Self-checking bench for srff_driver; follows SRFF_DRIVER_VERIFY_EN like the design.
module tb_srff_driver;

`ifdef SRFF_DRIVER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_len;
  logic       q_in;
  logic       s, r, busy, done, err;

  logic qf = 1'b0;
  logic follow;
  logic q_force;

  int n_vec = 0;
  int n_err = 0;

  srff_driver #(.LEN_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_len   (req_len),
    .q_in      (q_in),
    .s         (s),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // A stand-in SR flop: q reflects the strobe one cycle later.
  always @(posedge clk) begin
    if (s)      qf <= 1'b1;
    else if (r) qf <= 1'b0;
  end
  assign q_in = follow ? qf : q_force;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: each accepted command is described by absolute cycle numbers.
  // Cycle c is the cycle that starts at rising edge c-1 (acceptance at edge N -> strobe in N+1..N+L).
  int cyc = 0;
  bit mvalid = 0;
  bit active = 0;
  bit m_hold, m_set, done_known, err_m;
  int acc_n, m_len, wait_start, done_cyc;

  always @(posedge clk) begin
    int e;
    e = cyc;
    if (rst) begin
      active = 0;
      err_m  = 0;
      mvalid = 1;
    end else begin
      if (VERIFY && active && !done_known && e >= wait_start) begin
        if (m_hold || (q_in == m_set)) begin
          done_cyc   = e + 1;
          done_known = 1;
        end else if (e == wait_start + TIMEOUT - 1) begin
          done_cyc   = e + 1;
          done_known = 1;
          err_m      = 1;
        end
      end
      if ((!active || (done_known && e >= done_cyc)) && req_valid) begin
        active     = 1;
        acc_n      = e;
        m_len      = (req_len == 0) ? 1 : int'(req_len);
        m_hold     = (req_op == 2'b00);
        m_set      = (req_op == 2'b10) || ((req_op == 2'b11) && !q_in);
        wait_start = e + m_len + 1;
        done_cyc   = e + m_len + 1;
        done_known = !VERIFY;
      end
    end
    cyc = e + 1;
  end

  always @(negedge clk) begin
    bit in_cmd, strobe, e_done;
    if (mvalid) begin
      in_cmd = active && (!done_known || cyc < done_cyc);
      strobe = active && (cyc <= acc_n + m_len) && !m_hold;
      e_done = active && done_known && (cyc == done_cyc);
      check("cycle_outs {ready,s,r,busy,done,err}", {req_ready, s, r, busy, done, err},
            {!in_cmd, strobe && m_set, strobe && !m_set, in_cmd, e_done, err_m});
      check("s_and_r", s & r, 0);
    end
  end

  // Called at a falling edge; returns at the falling edge of the first strobe cycle.
  task automatic send(input logic [1:0] op, input logic [3:0] len);
    bit ok = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_len   = len;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("send_ready_seen", ok, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] len,
                         input int exp_k, input int exp_s, input int exp_r);
    int k = 1, sc = 0, rc = 0;
    bit seen = 0;
    send(op, len);
    for (int i = 0; i < 200; i++) begin
      sc += int'(s);
      rc += int'(r);
      if (done) begin seen = 1; break; end
      @(negedge clk);
      k++;
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_done_cycle"}, k, exp_k);
    check({name, "_s_cycles"}, sc, exp_s);
    check({name, "_r_cycles"}, rc, exp_r);
  endtask

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("wait_ready", ok, 1);
  endtask

  initial begin
    int gap, nacc;
    bit saw_done;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_len = 4'd0;
    follow = 1'b1; q_force = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", {req_ready, s, r, busy, done, err}, 6'b100000);
    rst = 1'b0;
    @(negedge clk);

    // Set, L=3, q follows s.
    run_cmd("set3", 2'b10, 4'd3, VERIFY ? 5 : 4, 3, 0);
    // Toggle from q=1 with len 0 -> one reset cycle.
    run_cmd("tgl_len0", 2'b11, 4'd0, VERIFY ? 3 : 2, 0, 1);
    // Set with q stuck low.
    follow = 1'b0; q_force = 1'b0;
    run_cmd("set_stuck", 2'b10, 4'd1, VERIFY ? 2 + TIMEOUT : 2, 1, 0);
    check("err_at_timeout", err, VERIFY);
    follow = 1'b1;
    run_cmd("rst_after_err", 2'b01, 4'd2, VERIFY ? 4 : 3, 0, 2);
    check("err_sticky", err, VERIFY);
    // Hold never times out.
    run_cmd("hold4", 2'b00, 4'd4, VERIFY ? 6 : 5, 0, 0);
    check("err_after_hold", err, VERIFY);

    // req_valid held high, alternating set/reset, L=2.
    wait_ready();
    req_valid = 1'b1; req_len = 4'd2; req_op = 2'b10;
    gap = 0; nacc = 0;
    for (int i = 0; i < 30; i++) begin
      if (req_ready) begin
        if (nacc > 0) check("b2b_spacing", gap, VERIFY ? 4 : 3);
        req_op = nacc[0] ? 2'b01 : 2'b10;
        nacc++;
        gap = 0;
      end
      @(negedge clk);
      gap++;
    end
    req_valid = 1'b0;
    check("b2b_accepts", nacc, VERIFY ? 8 : 10);
    @(negedge clk);
    wait_ready();

    // Reset in the 2nd strobe cycle of a long set.
    send(2'b10, 4'd5);
    @(negedge clk);
    check("abort_s_before", s, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs", {req_ready, s, r, busy, done, err}, 6'b100000);
    rst = 1'b0;
    saw_done = 0;
    repeat (8) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("abort_no_done", saw_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/srff_driver.md
# srff_driver

Sequential command driver for the set/reset flip-flop interface. It accepts set, reset, toggle and hold commands over a valid/ready handshake and converts them into clean `s`/`r` strobes of programmable length. It never drives `s=r=1`, the forbidden input combination of the flop. It sits upstream of the SR flop and, optionally, watches the flop's `q` to confirm that each command took effect.

## Interface
- `LEN_W`, 4: width of the strobe-length field.
- `TIMEOUT`, 8: cycles allowed for `q` to reach its target after the strobe ends. Used only with the verify feature; legal range is 1 to 255.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req_valid` input 1: a command is offered.
- `req_ready` output 1: the block can accept a command.
- `req_op` input 2: command code. 00 = hold, 01 = reset, 10 = set, 11 = toggle.
- `req_len` input `LEN_W`: strobe length in cycles. A value of 0 is treated as 1.
- `q_in` input 1: `q` of the driven flop.
- `s` output 1: set strobe.
- `r` output 1: reset strobe.
- `busy` output 1: a command is in progress.
- `done` output 1: one-cycle pulse when a command completes.
- `err` output 1: sticky verify failure. It clears only on `rst`.

## Operation
- States are IDLE, DRIVE and WAIT_Q. WAIT_Q exists only with the verify feature.
- IDLE:
  - `req_ready=1` and `busy=0`.
  - A command is accepted when `req_valid && req_ready` at a clock edge.
  - On acceptance: latch the op, load the counter with `max(req_len,1)`, go to DRIVE.
- Toggle resolves at acceptance from the current `q_in`: `q_in=0` gives set, `q_in=1` gives reset. The resolved target is latched.
- DRIVE:
  - Drive `s` for set, `r` for reset, or neither for hold.
  - Decrement the counter every cycle.
  - When the counter reaches 1, leave DRIVE on the next edge.
  - Without verify, go to IDLE and pulse `done`.
  - With verify, go to WAIT_Q.
- WAIT_Q:
  - Drive `s=r=0`.
  - Success when `q_in` equals the target: pulse `done`, return to IDLE. For set the target is 1, for reset it is 0. Hold always passes on the first WAIT_Q cycle.
  - Failure after `TIMEOUT` cycles in WAIT_Q without a match: set `err`, pulse `done`, return to IDLE.
- Invariant: `s & r` is 0 in every cycle, including reset and every transition.
- `req_valid` while busy is ignored. No command is queued.
- Reset mid-command aborts the command immediately: `s` and `r` drop on the same edge, and no `done` pulse is produced.
- `req_op` and `req_len` are sampled only at acceptance. Changes to them mid-command have no effect.

## Timing
- Reset values: `req_ready=1`, `s=0`, `r=0`, `busy=0`, `done=0`, `err=0`, state IDLE.
- All outputs are registered.
- Acceptance at edge N means the strobe is high in cycles N+1 through N+L, where L = `max(req_len,1)`.
- Without verify, `done` is high in cycle N+L+1 and `req_ready` returns in the same cycle. Back-to-back commands are therefore spaced at least L+1 cycles apart.
- With verify, WAIT_Q begins at cycle N+L+1:
  - If `q_in` matches in WAIT_Q cycle k (k ≥ 1), `done` is high in the following cycle.
  - On timeout, `err` and `done` rise together in cycle N+L+1+`TIMEOUT`.
- `done` never overlaps `s` or `r`.

## Configuration
- Macro: `SRFF_DRIVER_VERIFY_EN`.
- Defined: WAIT_Q, the timeout counter and `err` are built as described above.
- Undefined:
  - WAIT_Q and the timeout counter are not generated.
  - `err` is tied to 0.
  - `q_in` is used only to resolve toggle.
  - The port list is identical in both builds.

## Structure
- Package `srff_pkg` holds:
  - `srff_op_t`, the 2-bit op enum (OP_HOLD, OP_RST, OP_SET, OP_TGL).
  - `srff_drv_state_t` (IDLE, DRIVE, WAIT_Q).
  - The illegal-input constant `SR_FORBIDDEN = 2'b11`, used by assertions.
- One sub-module, `srff_drv_cnt`, is natural: a loadable down-counter with a terminal flag, instantiated for the strobe length and, under the macro, for the timeout.

## Test plan
- Reset release, then set with `req_len=3` while `q_in` follows `s` one cycle later -> `s` high for exactly 3 cycles, `done` 1 cycle after the last strobe (verify build: 1 cycle after the `q` match), `err=0`.
- Toggle with `q_in=1` and `req_len=0` -> `r` high for exactly 1 cycle and `s` never rises.
- Set with `q_in` stuck at 0, verify build, `TIMEOUT=8` -> `err` and `done` rise together 8 cycles after the strobe ends. `err` stays high through later successful commands until `rst`.
- `req_valid` held high with alternating set and reset ops -> each command accepted only while `req_ready=1`, commands spaced by L+1 cycles (plus WAIT_Q time in the verify build), and `s & r` equals 0 in every cycle.
- `rst` asserted in the 2nd cycle of a set with `req_len=5` -> `s=0`, `busy=0`, `req_ready=1` on the next edge, and no `done` pulse.
- Hold with `req_len=4` -> `s=r=0` for 4 cycles, then `done`, with no timeout in either build.
